// File: rtl/trojan3_crossbar_rr_param.sv
// -----------------------------------------------------------------------------
// trojan3_crossbar_rr_param
//
// NUM_INPUTS x NUM_OUTPUTS crossbar. Each output has a round-robin arbiter and
// a one-entry output register. A counter-triggered payload adds
// DATA_INCREMENT to every word accepted while the payload is active. This is
// the trojaned benchmark host of the trojan3 family.
//
// Handshake: an input word moves in the cycle where in_valid[i] && in_ready[i].
// in_ready is combinational: it depends on in_valid, in_dest, the RR pointers,
// out_valid and out_ready. An output word is consumed in the cycle where
// out_valid[o] && out_ready[o]. A slot that is being drained can accept a new
// word in the same cycle, so a stream runs without bubbles.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_data    flattened input data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_dest    flattened destination per input, channel i at [i*SEL_W +: SEL_W]
//   in_valid   input valid per channel
//   in_ready   input accepted this cycle (combinational)
//   out_data   flattened registered output data
//   out_valid  registered output valid
//   out_ready  downstream ready per output
//   busy       registered OR of in_valid
// -----------------------------------------------------------------------------
module trojan3_crossbar_rr_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_OUTPUTS    = 4,
  parameter int SEL_W          = $clog2(NUM_OUTPUTS),
  parameter int CNT_WIDTH      = 10,
  parameter int THRESHOLD      = 458,
  parameter int DATA_INCREMENT = 9,
  parameter int COUNT_MODE     = 0,
  parameter int ONE_SHOT       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_INPUTS*SEL_W-1:0]       in_dest,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  output logic [NUM_INPUTS-1:0]             in_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic                              busy
);

  localparam int PTR_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_WIDTH-1:0]  THR = CNT_WIDTH'(THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(DATA_INCREMENT);

  // Input index base+off, wrapped modulo NUM_INPUTS (off < NUM_INPUTS).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_INPUTS) s = s - NUM_INPUTS;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0]              ptr_q   [NUM_OUTPUTS];
  logic [PTR_W-1:0]              ptr_d   [NUM_OUTPUTS];
  logic [PTR_W-1:0]              gnt_idx [NUM_OUTPUTS];
  logic [NUM_INPUTS-1:0]         req     [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]        gnt_hit;
  logic [NUM_OUTPUTS-1:0]        gnt_vld;
  logic [NUM_OUTPUTS-1:0]        can_load;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_OUTPUTS-1:0]        out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                          fired_q, fired_d;
  logic                          busy_q;
  logic                          any_xfer;
  logic                          adv;
  logic                          trig;
  logic                          active;

  // Request matrix. A destination >= NUM_OUTPUTS matches no output and so is
  // never granted; that input simply stalls.
  always_comb begin
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        req[o][i] = in_valid[i] && (in_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
      end
    end
  end

  // Round-robin search. Scanning offsets from high to low lets the smallest
  // offset from ptr overwrite any earlier hit, so the winner is the first
  // requester at or above ptr, wrapping around.
  always_comb begin
    can_load = ~out_valid_q | out_ready;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      gnt_hit[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (req[o][wrap_idx(ptr_q[o], k)]) begin
          gnt_hit[o] = 1'b1;
          gnt_idx[o] = wrap_idx(ptr_q[o], k);
        end
      end
      gnt_vld[o] = gnt_hit[o] & can_load[o];
    end
  end

  // Each input names one destination, so it can win at most one output.
  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      if (gnt_vld[o]) in_ready[gnt_idx[o]] = 1'b1;
    end
  end

  assign any_xfer = |(in_valid & in_ready);

  // Trigger counter and payload activation.
  assign adv    = (COUNT_MODE == 0) ? 1'b1 : any_xfer;
  assign trig   = (cnt_q == THR);
  assign active = trig | fired_q;

  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    if (adv) begin
      cnt_d = trig ? '0 : cnt_q + 1'b1;
      // fired_q stays 0 in periodic mode, so active reduces to trig there.
      if ((ONE_SHOT != 0) && trig) fired_d = 1'b1;
    end
  end

  // Output slots and RR pointers. A drained slot reloads in the same cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      ptr_d[o] = ptr_q[o];
      if (gnt_vld[o]) begin
        out_valid_d[o] = 1'b1;
        out_data_d[o*DATA_WIDTH +: DATA_WIDTH] =
          active ? in_data[int'(gnt_idx[o])*DATA_WIDTH +: DATA_WIDTH] + INC
                 : in_data[int'(gnt_idx[o])*DATA_WIDTH +: DATA_WIDTH];
        ptr_d[o] = wrap_idx(gnt_idx[o], 1);
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      fired_q     <= 1'b0;
      for (int o = 0; o < NUM_OUTPUTS; o++) ptr_q[o] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= |in_valid;
      cnt_q       <= cnt_d;
      fired_q     <= fired_d;
      for (int o = 0; o < NUM_OUTPUTS; o++) ptr_q[o] <= ptr_d[o];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/trojan3_crossbar_rr_param.md
Name: trojan3_crossbar_rr_param

Overview:
- Parametrised successor to the trojan3 crossbar host: NUM_INPUTS x NUM_OUTPUTS crossbar.
- Each output has a true round-robin arbiter, a valid/ready handshake on both sides, and a one-entry output register per output.
- Embeds a generalised Trojan3-style payload: a counter-triggered additive data corruption with selectable count source (cycles or transfers) and selectable firing mode (periodic or one-shot latch).
- Used as a trojaned benchmark host in the trojan3 family.

Parameters:
- DATA_WIDTH, 8: payload width per channel.
- NUM_INPUTS, 4: input channel count, >=2.
- NUM_OUTPUTS, 4: output channel count, >=2.
- SEL_W, $clog2(NUM_OUTPUTS): destination select width.
- CNT_WIDTH, 10: trigger counter width.
- THRESHOLD, 458: trigger compare value, must be < 2^CNT_WIDTH.
- DATA_INCREMENT, 9: value added to corrupted data, truncated to DATA_WIDTH.
- COUNT_MODE, 0: 0 = count cycles, 1 = count cycles with at least one accepted transfer.
- ONE_SHOT, 0: 0 = periodic trigger, 1 = payload latches on after first trigger.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_INPUTS*DATA_WIDTH  flattened input data; channel i is at [i*DATA_WIDTH +: DATA_WIDTH].
- in_dest  in  NUM_INPUTS*SEL_W  flattened destination per input.
- in_valid  in  NUM_INPUTS  input valid.
- in_ready  out  NUM_INPUTS  input accepted this cycle; combinational.
- out_data  out  NUM_OUTPUTS*DATA_WIDTH  flattened registered output data.
- out_valid  out  NUM_OUTPUTS  registered output valid.
- out_ready  in  NUM_OUTPUTS  downstream ready.
- busy  out  1  registered OR of in_valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_data=0, busy=0.
  - All RR pointers=0, trigger counter=0, fired latch=0.
  - Reset overrides any in-flight transfer; no data survives reset.
- Output slot o can load when !out_valid[o] | out_ready[o].
- Requests: input i requests output o when in_valid[i] && in_dest[i]==o. Destinations >= NUM_OUTPUTS are never granted; that input stalls with in_ready=0.
- Arbitration per output:
  - Among the requesting inputs, grant the first index >= ptr[o], searching upward and wrapping modulo NUM_INPUTS.
  - Grant only if slot o can load.
  - in_ready[i]=1 only for granted inputs. Each input targets one output, so at most one grant per input.
- Transfer occurs when in_valid & in_ready.
  - On transfer, ptr[o] <= (granted index + 1) mod NUM_INPUTS.
  - With no transfer, ptr[o] holds.
- Latency: data accepted at edge t appears on out_data/out_valid after edge t.
- Throughput: 1 transfer per output per cycle while out_ready=1. All outputs run independently and concurrently.
- Output slot update at each edge:
  - Transfer into o: out_valid[o]<=1 and out_data[o] loads the accepted data.
  - Else if out_ready[o]: out_valid[o]<=0 and out_data[o] holds.
  - Else: hold both.
- Trigger counter cnt (CNT_WIDTH bits):
  - Advance event: every cycle (COUNT_MODE=0), or any cycle with >=1 transfer (COUNT_MODE=1).
  - On an advance event, cnt<=0 if cnt==THRESHOLD, else cnt+1. The period is THRESHOLD+1 events.
  - trig = (cnt==THRESHOLD), combinational on the current cnt.
- Payload activation:
  - ONE_SHOT=1: fired<=1 when trig and an advance event occur together; active = trig | fired.
  - ONE_SHOT=0: active = trig.
- Corruption: every transfer accepted while active=1 loads (in_data_i + DATA_INCREMENT) mod 2^DATA_WIDTH. This applies to all outputs in that cycle. Otherwise data passes unmodified.
- busy <= |in_valid each cycle.

Test Plan:
All scenarios use DATA_WIDTH=8, NUM_INPUTS=4, NUM_OUTPUTS=4, DATA_INCREMENT=9 unless stated.
1. Reset mid-traffic: all inputs valid, rst_n=0 for 2 cycles -> out_valid=0, out_data=0, busy=0 after the first reset edge. The first post-reset grant for each output goes to the lowest requesting index.
2. Single transfer: input 2, dest 1, data 0x3C, trigger far away -> in_ready[2]=1 the same cycle; out_valid[1]=1 and out_data[1]=0x3C the next cycle; other outputs stay invalid.
3. Contention: inputs 0, 1, 3 held valid to dest 2, out_ready=1 -> grants in order 0, 1, 3, 0, 1, 3; each input is blocked exactly 2 of every 3 cycles.
4. Backpressure: out_valid[0]=1 with out_ready[0]=0 for 5 cycles -> in_ready to dest 0 stays 0 and out_data[0] holds. On out_ready=1, the slot drains and reloads the same cycle with no bubble.
5. Periodic trigger: COUNT_MODE=0, ONE_SHOT=0, THRESHOLD=5. Transfer data 0xFA in the cycle cnt==5 -> output 0x03 (wraps modulo 2^8). A transfer one cycle later passes unmodified. The next corruption is 6 cycles later.
6. One-shot, transfer-counted: COUNT_MODE=1, ONE_SHOT=1, THRESHOLD=5.
   - Idle cycles do not advance cnt.
   - The 6th transfer cycle and every later transfer are incremented by 9.
   - rst_n clears fired and restores clean pass-through.
